// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter guarding one shared WIDTH-bit register: IDLE -> GRANT -> COMMIT.
// Optional saturating write counter output wr_count when REG_ACCESS_ARBITER_WRITE_COUNT_EN is defined.
module reg_access_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           ack,
    output logic [WIDTH-1:0]           q,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   owner
`ifdef REG_ACCESS_ARBITER_WRITE_COUNT_EN
    ,
    output logic [15:0]                wr_count
`endif
);

    localparam int IdxW = $clog2(N_REQ);

    typedef enum logic [1:0] {StIdle, StGrant, StCommit} state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [IdxW-1:0]    win_idx;
    logic               win_found;
    logic [N_REQ-1:0]   win_onehot;
    logic [WIDTH-1:0]   sel_data;
    logic [IdxW-1:0]    ptr_next;
    int                 cand;

    // Scan upward from ptr with wrap; the first set request wins.
    always_comb begin
        win_idx   = ptr_q;
        win_found = 1'b0;
        cand      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = IdxW'(cand);
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        sel_data   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_onehot[i] = (win_idx == IdxW'(i));
            if (owner_q == IdxW'(i)) begin
                sel_data = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        q_d     = q_q;
        unique case (state_q)
            StIdle: begin
                gnt_d = '0;
                if (win_found) begin
                    owner_d = win_idx;
                    gnt_d   = win_onehot;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (req[owner_q]) begin
                    q_d     = sel_data;
                    ack_d   = gnt_q;
                    state_d = StCommit;
                end else begin
                    // Abort: ptr stays put so the same requester wins a re-request.
                    gnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StCommit: begin
                gnt_d   = '0;
                ptr_d   = ptr_next;
                state_d = StIdle;
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
        end
    end

`ifdef REG_ACCESS_ARBITER_WRITE_COUNT_EN
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        wr_count_d = wr_count_q;
        if (state_q == StGrant && req[owner_q] && wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;
`endif

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign q     = q_q;
    assign owner = owner_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Scoreboard bench for reg_access_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level round-robin model.
module tb_reg_access_arbiter;

    localparam int WIDTH = 8;
    localparam int N_REQ = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*WIDTH-1:0] wdata = '0;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       q;
    logic                   busy;
    logic [1:0]             owner;
`ifdef REG_ACCESS_ARBITER_WRITE_COUNT_EN
    logic [15:0]            wr_count;
`endif

    reg_access_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wdata   (wdata),
        .gnt     (gnt),
        .ack     (ack),
        .q       (q),
        .busy    (busy),
        .owner   (owner)
`ifdef REG_ACCESS_ARBITER_WRITE_COUNT_EN
        ,
        .wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = waiting, 1 = winner chosen, 2 = write done.
    typedef struct {
        int         idx;
        logic [7:0] data;
    } ack_exp_t;

    ack_exp_t   ack_exp_q[$];
    int         m_phase = 0;
    int         m_ptr = 0;
    int         m_win = 0;
    logic [7:0] m_q = '0;
    int         m_cnt = 0;

    task automatic model_step();
        int  idx;
        bit  found;
        if (reset) begin
            m_phase = 0;
            m_ptr   = 0;
            m_win   = 0;
            m_q     = '0;
            m_cnt   = 0;
            ack_exp_q.delete();
        end else begin
            case (m_phase)
                0: if (req != 0) begin
                    found = 0;
                    for (int k = 0; k < N_REQ; k++) begin
                        idx = (m_ptr + k) % N_REQ;
                        if (!found && req[idx]) begin
                            found = 1;
                            m_win = idx;
                        end
                    end
                    m_phase = 1;
                end
                1: if (req[m_win]) begin
                    m_q = wdata[m_win*WIDTH +: WIDTH];
                    ack_exp_q.push_back('{m_win, m_q});
                    if (m_cnt < 65535) m_cnt++;
                    m_phase = 2;
                end else begin
                    m_phase = 0;
                end
                default: begin
                    m_ptr   = (m_win + 1) % N_REQ;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // Monitor: compares visible state each cycle and pops the scoreboard on every ack.
    initial forever begin
        logic [3:0] exp_gnt;
        logic [3:0] exp_ack;
        ack_exp_t   e;
        @(negedge clk);
        exp_gnt = (m_phase != 0) ? (4'b0001 << m_win) : 4'b0000;
        exp_ack = (m_phase == 2) ? (4'b0001 << m_win) : 4'b0000;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("ack", 32'(ack), 32'(exp_ack));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("owner", 32'(owner), 32'(m_win));
        check("q", 32'(q), 32'(m_q));
`ifdef REG_ACCESS_ARBITER_WRITE_COUNT_EN
        check("wr_count", 32'(wr_count), 32'(m_cnt));
`endif
        if (ack != 0) begin
            if (ack_exp_q.size() == 0) begin
                check("ack_unexpected", 32'(ack), 32'd0);
            end else begin
                e = ack_exp_q.pop_front();
                check("ack_winner", 32'(ack), 32'(4'b0001 << e.idx));
                check("ack_data", 32'(q), 32'(e.data));
            end
        end
    end

    task automatic step(input logic [3:0] r, input logic [31:0] w);
        req   = r;
        wdata = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] r;
        r = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single writer
        step(4'b0001, 32'h0000_00A5);
        step(4'b0001, 32'h0000_00A5);
        step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);

        // Contention: grants 0,1,2,3,0
        repeat (15) step(4'b1111, 32'h4433_2211);
        step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);

        // Abort on requester 2, then re-request
        step(4'b0100, 32'h00EE_0000);
        step(4'b0000, 32'h00EE_0000);
        step(4'b0000, 32'h0);
        step(4'b0100, 32'h0077_0000);
        step(4'b0100, 32'h0077_0000);
        step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);

        // Reset while in COMMIT
        step(4'b1111, 32'h9988_7766);
        step(4'b1111, 32'h9988_7766);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        step(4'b1000, 32'h5A00_0000);
        step(4'b1000, 32'h5A00_0000);
        step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);

        // Last winner 3, then 0 and 3 compete
        repeat (6) step(4'b1001, 32'hC300_00C0);
        step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);

        // Random traffic with occasional asynchronous reset pulses
        repeat (600) begin
            if ($urandom_range(1) == 0) r = 4'($urandom_range(15));
            if ($urandom_range(99) == 0) begin
                reset = 1'b1;
                #2 reset = 1'b0;
            end
            step(r, $urandom);
        end

        repeat (4) step(4'b0000, 32'h0);
        check("ack_queue_drained", 32'(ack_exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
